ball_game_ctrl: RTL and testbench

- Sequences a match of the VGA ball game: idle, serve delay, play, point scoring and game over.
- Each frame it evaluates the ball position against the walls and both paddles.
- It drives the ball core's crash vector, move enable and ball reset, and keeps the score for both players.
- It sits between the ball core, the paddle blocks and the VGA timing generator; scores and state go to the renderer.

---
 rtl/ball_game_ctrl_if.sv | 24 ++
 rtl/ball_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ball_game_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ball_game_ctrl_if.sv
// Ball-core bus: ball/paddle positions in, crash/move/hold controls out.
// Latency: none, wires only.
// Backpressure: none; controls are single-cycle pulses or levels.
interface ball_game_ctrl_if;
  logic [9:0] iBall_x;
  logic [9:0] iBall_y;
  logic [9:0] iPaddle_l_y;
  logic [9:0] iPaddle_r_y;
  logic [3:0] oCrash;
  logic       oMove_en;
  logic       oBall_rst_n;

  // Controller side: reads positions, drives the ball core controls.
  modport master (
    input  iBall_x, iBall_y, iPaddle_l_y, iPaddle_r_y,
    output oCrash, oMove_en, oBall_rst_n
  );

  // Ball-core / paddle side: publishes positions, consumes controls.
  modport slave (
    output iBall_x, iBall_y, iPaddle_l_y, iPaddle_r_y,
    input  oCrash, oMove_en, oBall_rst_n
  );
endinterface

// File: rtl/ball_game_ctrl.sv
// Match sequencer for the VGA ball game: serve, play, scoring, game over.
// Latency: frame tick 3-4 clocks after vsync fall; crash/move 1 clock after tick.
// Backpressure: none; the ball core must take crash/move on the pulse edge.
module ball_game_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int STEP         = 2,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_L_X   = 16,
  parameter int PADDLE_R_X   = 616,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             iVsync_n,
  input  logic             iStart,
  ball_game_ctrl_if.master bus,
  output logic [3:0]       oScore_l,
  output logic [3:0]       oScore_r,
  output logic [2:0]       oState,
  output logic [1:0]       oWinner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // Geometry is compared in 11 bits so ball+size sums can never wrap.
  localparam logic [10:0] K_VACT = 11'(V_ACTIVE);
  localparam logic [10:0] K_BALL = 11'(BALL_SIZE);
  localparam logic [10:0] K_STEP = 11'(STEP);
  localparam logic [10:0] K_PW   = 11'(PADDLE_W);
  localparam logic [10:0] K_PH   = 11'(PADDLE_H);
  localparam logic [10:0] K_PLX  = 11'(PADDLE_L_X);
  localparam logic [10:0] K_PRX  = 11'(PADDLE_R_X);
  localparam logic [7:0]  K_SRV_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]  K_WIN  = 4'(WIN_SCORE);

  state_e      state_q, state_d;
  logic [2:0]  vs_q;            // [0]=stage1, [1]=stage2, [2]=stage3
  logic        tick_q;
  logic        start_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]  winner_q, winner_d;
  logic        scorer_q, scorer_d;  // 1: right player scored, 0: left
  logic [3:0]  crash_q, crash_d;
  logic        move_q, move_d;

  logic [10:0] bx, by, pl, pr;
  logic        hit_up, hit_dn, hit_l, hit_r, miss_l, miss_r;
  logic        start_edge;
  logic [3:0]  inc_l, inc_r;

  assign bx = {1'b0, bus.iBall_x};
  assign by = {1'b0, bus.iBall_y};
  assign pl = {1'b0, bus.iPaddle_l_y};
  assign pr = {1'b0, bus.iPaddle_r_y};

  assign hit_up = by <= K_STEP;
  assign hit_dn = (by + K_BALL) >= (K_VACT - K_STEP);
  assign hit_l  = (bx <= K_PLX + K_PW) && (bx + K_STEP >= K_PLX) &&
                  (by + K_BALL > pl) && (by < pl + K_PH);
  assign hit_r  = (bx + K_BALL >= K_PRX) && (bx + K_BALL <= K_PRX + K_PW + K_STEP) &&
                  (by + K_BALL > pr) && (by < pr + K_PH);
  assign miss_l = (bx + K_STEP) < K_PLX;
  assign miss_r = (bx + K_BALL) > (K_PRX + K_PW + K_STEP);

  assign start_edge = iStart & ~start_q;
  assign inc_l = (score_l_q == 4'hF) ? score_l_q : score_l_q + 4'd1;
  assign inc_r = (score_r_q == 4'hF) ? score_r_q : score_r_q + 4'd1;

  // Vsync synchroniser, registered falling-edge tick, and start edge history.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q    <= 3'b111;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      vs_q    <= {vs_q[1:0], iVsync_n};
      tick_q  <= vs_q[2] & ~vs_q[1];
      start_q <= iStart;
    end
  end

  // Match state, counters, scores and the registered ball-core pulses.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      winner_q  <= 2'b00;
      scorer_q  <= 1'b0;
      crash_q   <= 4'd0;
      move_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      scorer_q  <= scorer_d;
      crash_q   <= crash_d;
      move_q    <= move_d;
    end
  end

  // Next-state and datapath updates; pulses default low outside a PLAY tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    scorer_d  = scorer_q;
    crash_d   = 4'd0;
    move_d    = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
          cnt_d     = 8'd0;
          state_d   = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick_q) begin
          if (cnt_q == K_SRV_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (tick_q) begin
          if (miss_l || miss_r) begin
            // A miss wins over any crash: no step this frame, just score.
            scorer_d = miss_l;
            state_d  = S_POINT;
          end else begin
            crash_d = {hit_l, hit_r, hit_up, hit_dn};
            move_d  = 1'b1;
          end
        end
      end
      S_POINT: begin
        cnt_d   = 8'd0;
        state_d = S_SERVE;
        if (scorer_q) begin
          score_r_d = inc_r;
          if (inc_r == K_WIN) begin
            winner_d = 2'b10;
            state_d  = S_OVER;
          end
        end else begin
          score_l_d = inc_l;
          if (inc_l == K_WIN) begin
            winner_d = 2'b01;
            state_d  = S_OVER;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.oCrash      = crash_q;
  assign bus.oMove_en    = move_q;
  assign bus.oBall_rst_n = (state_q == S_PLAY);
  assign oScore_l        = score_l_q;
  assign oScore_r        = score_r_q;
  assign oState          = state_q;
  assign oWinner         = winner_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Directed bench for ball_game_ctrl with a short serve and a 2-point match.
// Latency: vsync is dropped on a negedge; the move pulse is expected 4 edges later.
// Backpressure: none; the bench observes every cycle around each frame.
module tb_ball_game_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sl, sr;
  logic [2:0] st;
  logic [1:0] win;

  ball_game_ctrl_if bus();

  ball_game_ctrl #(.SERVE_FRAMES(3), .WIN_SCORE(2)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .iVsync_n (vsync),
    .iStart   (start),
    .bus      (bus),
    .oScore_l (sl),
    .oScore_r (sr),
    .oState   (st),
    .oWinner  (win)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0] bx, by, pl, pr;
    logic [3:0] crash;
    int         mv;
    int         pt;
    logic [2:0] st;
    logic [3:0] sl, sr;
    logic [1:0] win;
  } vec_t;

  vec_t vt[8];

  int         f_mv, f_pt, f_play, f_rstn, f_mvidx;
  logic [3:0] f_crash;

  // One 100-clock video frame; records what the DUT did around the tick.
  task automatic frame();
    f_mv = 0; f_pt = 0; f_play = -1; f_rstn = -1; f_mvidx = -1; f_crash = 4'd0;
    @(negedge clk) vsync = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.oMove_en) begin
        f_mv++;
        if (f_mvidx < 0) f_mvidx = i;
      end
      f_crash |= bus.oCrash;
      if (st == 3'd3) f_pt++;
      if (st == 3'd2 && f_play < 0) f_play = i;
      if (bus.oBall_rst_n && f_rstn < 0) f_rstn = i;
      if (i == 5) vsync = 1'b1;
    end
    repeat (88) @(negedge clk);
  endtask

  task automatic centre();
    bus.iBall_x = 10'd300; bus.iBall_y = 10'd200;
    bus.iPaddle_l_y = 10'd200; bus.iPaddle_r_y = 10'd200;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    vt[0] = '{10'd300, 10'd1,   10'd200, 10'd200, 4'b0010, 1, 0, 3'd2, 4'd0, 4'd0, 2'b00};
    vt[1] = '{10'd300, 10'd470, 10'd200, 10'd200, 4'b0001, 1, 0, 3'd2, 4'd0, 4'd0, 2'b00};
    vt[2] = '{10'd24,  10'd100, 10'd90,  10'd200, 4'b1000, 1, 0, 3'd2, 4'd0, 4'd0, 2'b00};
    vt[3] = '{10'd24,  10'd100, 10'd200, 10'd200, 4'b0000, 1, 0, 3'd2, 4'd0, 4'd0, 2'b00};
    vt[4] = '{10'd616, 10'd1,   10'd200, 10'd0,   4'b0110, 1, 0, 3'd2, 4'd0, 4'd0, 2'b00};
    vt[5] = '{10'd10,  10'd100, 10'd200, 10'd200, 4'b0000, 0, 1, 3'd1, 4'd0, 4'd1, 2'b00};
    vt[6] = '{10'd620, 10'd1,   10'd200, 10'd200, 4'b0000, 0, 1, 3'd1, 4'd1, 4'd1, 2'b00};
    vt[7] = '{10'd620, 10'd470, 10'd200, 10'd200, 4'b0000, 0, 1, 3'd4, 4'd2, 4'd1, 2'b01};

    centre();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_crash", bus.oCrash, 0);
    chk("rst_move", bus.oMove_en, 0);
    chk("rst_ballrst", bus.oBall_rst_n, 0);
    chk("rst_scores", {sl, sr}, 0);
    chk("rst_winner", win, 0);
    @(negedge clk) rst_n = 1'b1;

    pulse_start();
    chk("start_to_serve", st, 1);
    frame();
    chk("serve_f1_state", st, 1);
    chk("serve_f1_ballrst", bus.oBall_rst_n, 0);
    frame();
    chk("serve_f2_state", st, 1);
    frame();
    chk("serve_f3_play_idx", f_play, 3);
    chk("serve_f3_ballrst_idx", f_rstn, 3);
    chk("serve_f3_no_move", f_mv, 0);
    chk("serve_f3_state", st, 2);

    for (int k = 0; k < 8; k++) begin
      bus.iBall_x = vt[k].bx; bus.iBall_y = vt[k].by;
      bus.iPaddle_l_y = vt[k].pl; bus.iPaddle_r_y = vt[k].pr;
      frame();
      chk($sformatf("v%0d_move_cnt", k), f_mv, vt[k].mv);
      chk($sformatf("v%0d_crash", k), f_crash, vt[k].crash);
      chk($sformatf("v%0d_point_cycles", k), f_pt, vt[k].pt);
      chk($sformatf("v%0d_state", k), st, vt[k].st);
      chk($sformatf("v%0d_score_l", k), sl, vt[k].sl);
      chk($sformatf("v%0d_score_r", k), sr, vt[k].sr);
      chk($sformatf("v%0d_winner", k), win, vt[k].win);
      if (k == 0) chk("move_latency_idx", f_mvidx, 3);
      if (vt[k].pt != 0 && vt[k].st == 3'd1) begin
        centre();
        frame(); frame(); frame();
        chk($sformatf("v%0d_reserve_play", k), st, 2);
      end
    end

    pulse_start();
    chk("over_restart_state", st, 1);
    chk("over_restart_scores", {sl, sr}, 0);
    chk("over_restart_winner", win, 0);
    centre();
    frame(); frame(); frame();
    chk("replay_state", st, 2);

    pulse_start();
    chk("start_ignored_in_play", st, 2);
    chk("start_ignored_scores", {sl, sr}, 0);

    begin
      int seen = 0;
      @(negedge clk) vsync = 1'b0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        @(negedge clk);
        if (bus.oMove_en) seen = 1;
      end
      chk("midplay_move_seen", seen, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", st, 0);
      chk("async_rst_move", bus.oMove_en, 0);
      chk("async_rst_crash", bus.oCrash, 0);
      chk("async_rst_ballrst", bus.oBall_rst_n, 0);
      chk("async_rst_scores_win", {sl, sr, win}, 0);
      vsync = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
